// File: rtl/rf_scan_serializer.sv
// rf_scan_serializer: snapshots the register-file scan bus and shifts it out as a framed serial stream
//   clk, rst_n     : core clock, asynchronous active-low reset
//   mem_scan_i     : NUM_WORDS x DATA_WIDTH snapshot bus (word 0 = x1 ... word 8 = x15)
//   capture_req_i  : capture and transmit request (level, sampled each clk)
//   clr_ovf_i      : clears overrun_o
//   scan_so_o      : serial data, stable for a whole bit period
//   scan_sclk_o    : serial strobe, rises mid-bit
//   scan_frame_o   : high while a frame is shifting
//   busy_o         : high outside IDLE
//   done_o         : one-cycle pulse after the parity bit
//   overrun_o      : sticky flag for a dropped capture request
//   seq_o          : completed frame count mod 256
module rf_scan_serializer #(
    parameter int NUM_WORDS = 9,
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV = 4,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem_scan_i,
    input  logic capture_req_i,
    input  logic clr_ovf_i,
    output logic scan_so_o,
    output logic scan_sclk_o,
    output logic scan_frame_o,
    output logic busy_o,
    output logic done_o,
    output logic overrun_o,
    output logic [7:0] seq_o
);
    localparam int DBITS = NUM_WORDS * DATA_WIDTH;
    localparam int FBITS = DBITS + 17;
    localparam int DW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DBITS + 8);
    typedef enum logic [2:0] {IDLE, HDR, SEQ, DATA, PAR} state_t;
    state_t state;
    logic [DW-1:0] div;
    logic [CW-1:0] cnt;
    // Whole frame (header, seq, data, parity) is latched at capture and shifted
    // out MSB first; the data section is never reloaded mid-frame.
    logic [FBITS-1:0] sh;
    logic [DBITS-1:0] data_ord;
    logic bit_end, last_bit;
    always_comb begin
        data_ord = '0;
        for (int k = 0; k < NUM_WORDS; k++)
            data_ord[(NUM_WORDS-1-k)*DATA_WIDTH +: DATA_WIDTH] = mem_scan_i[k];
    end
    assign bit_end = div == DW'(CLK_DIV - 1);
    assign last_bit = state == DATA ? cnt == CW'(DBITS - 1) : state == PAR ? 1'b1 : cnt == CW'(7);
    assign busy_o = state != IDLE;
    assign scan_frame_o = busy_o;
    // Shifting zeros in behind the frame leaves sh clear once the parity bit is out.
    assign scan_so_o = sh[FBITS-1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            div <= '0;
            cnt <= '0;
            sh <= '0;
            scan_sclk_o <= 1'b0;
            done_o <= 1'b0;
            overrun_o <= 1'b0;
            seq_o <= 8'd0;
        end else begin
            done_o <= 1'b0;
            if (busy_o && capture_req_i)
                overrun_o <= 1'b1;
            else if (clr_ovf_i)
                overrun_o <= 1'b0;
            if (state == IDLE) begin
                scan_sclk_o <= 1'b0;
                if (capture_req_i) begin
                    state <= HDR;
                    div <= '0;
                    cnt <= '0;
                    sh <= {HEADER, seq_o, data_ord, ^mem_scan_i};
                end
            end else begin
                div <= bit_end ? '0 : div + 1'b1;
                // Registered strobe: high for divider values CLK_DIV/2 .. CLK_DIV-1.
                scan_sclk_o <= !bit_end && div >= DW'(CLK_DIV / 2 - 1);
                if (bit_end) begin
                    sh <= sh << 1;
                    cnt <= last_bit ? '0 : cnt + 1'b1;
                    if (last_bit) begin
                        state <= state == HDR ? SEQ : state == SEQ ? DATA : state == DATA ? PAR : IDLE;
                        if (state == PAR) begin
                            done_o <= 1'b1;
                            seq_o <= seq_o + 8'd1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rf_scan_serializer.sv
// tb_rf_scan_serializer: randomized self-checking bench comparing deserialized frames against a frame model
module tb_rf_scan_serializer;
    localparam int NW = 9;
    localparam int WD = 32;
    localparam int CD = 4;
    localparam int FB = NW * WD + 17;
    localparam int WFB = WD + 17;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [NW-1:0][WD-1:0] mem = '0;
    logic req = 1'b0, clr = 1'b0;
    logic so, sclk, frame, busy, done, ovr;
    logic [7:0] seq;
    logic [0:0][WD-1:0] w_mem = '0;
    logic w_req = 1'b0;
    logic w_so, w_sclk, w_frame, w_busy, w_done, w_ovr;
    logic [7:0] w_seq;
    int vectors = 0, errors = 0, exp_seq = 0;
    bit rx[$];
    bit exp_q[$];
    int frame_cycles = 0, sclk_edges = 0, done_cnt = 0;
    logic prev_sclk = 1'b0;

    always #5 clk = ~clk;

    rf_scan_serializer #(.NUM_WORDS(NW), .DATA_WIDTH(WD), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .mem_scan_i(mem), .capture_req_i(req), .clr_ovf_i(clr),
        .scan_so_o(so), .scan_sclk_o(sclk), .scan_frame_o(frame), .busy_o(busy),
        .done_o(done), .overrun_o(ovr), .seq_o(seq)
    );

    rf_scan_serializer #(.NUM_WORDS(1), .DATA_WIDTH(WD), .CLK_DIV(2)) wdut (
        .clk(clk), .rst_n(rst_n), .mem_scan_i(w_mem), .capture_req_i(w_req), .clr_ovf_i(1'b0),
        .scan_so_o(w_so), .scan_sclk_o(w_sclk), .scan_frame_o(w_frame), .busy_o(w_busy),
        .done_o(w_done), .overrun_o(w_ovr), .seq_o(w_seq)
    );

    // Receiver: latch data on each strobe rising edge, and check the idle line stays low.
    always @(negedge clk) begin
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            rx.push_back(so);
            sclk_edges++;
        end
        prev_sclk = sclk;
        if (frame === 1'b1) frame_cycles++;
        if (done === 1'b1) done_cnt++;
        if (rst_n && frame === 1'b0) begin
            vectors++;
            if (so !== 1'b0) begin
                errors++;
                $display("FAIL so_idle: scan_so_o=%b required 0 at %0t", so, $time);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        rx.delete();
        frame_cycles = 0;
        sclk_edges = 0;
        done_cnt = 0;
    endtask

    task automatic make_exp(input logic [NW-1:0][WD-1:0] w, input int s);
        logic [7:0] hdr = 8'hA5;
        logic [7:0] sb = 8'(s);
        int ones = 0;
        exp_q.delete();
        for (int i = 7; i >= 0; i--) exp_q.push_back(hdr[i]);
        for (int i = 7; i >= 0; i--) exp_q.push_back(sb[i]);
        for (int k = 0; k < NW; k++) begin
            ones += $countones(w[k]);
            for (int b = WD - 1; b >= 0; b--) exp_q.push_back(w[k][b]);
        end
        exp_q.push_back(bit'(ones % 2));
    endtask

    function automatic int diff_bits();
        int n = (rx.size() == exp_q.size()) ? 0 : 1000;
        for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
            if (rx[i] != exp_q[i]) n++;
        return n;
    endfunction

    function automatic logic [7:0] rx_byte(input int off);
        logic [7:0] v = 'x;
        if (rx.size() >= off + 8)
            for (int i = 0; i < 8; i++) v[7-i] = rx[off+i];
        return v;
    endfunction

    task automatic start(input logic [NW-1:0][WD-1:0] w);
        mem = w;
        req = 1'b1;
        tick;
        req = 1'b0;
    endtask

    task automatic wait_done(input bit scramble, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (scramble)
                for (int k = 0; k < NW; k++) mem[k] = $urandom;
            tick;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({so, sclk, frame, busy, done, ovr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000000", {so, sclk, frame, busy, done, ovr});
        end
        vectors++;
        if (seq !== 8'h00) begin
            errors++;
            $display("FAIL reset_seq: got %h required 00", seq);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick;
        vectors++;
        if (busy !== 1'b0 || ovr !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b overrun=%b required 0 0", busy, ovr);
        end
    endtask

    task automatic test_basic;
        logic [NW-1:0][WD-1:0] w;
        bit ok;
        for (int k = 0; k < NW; k++) w[k] = 32'h1000_0000 + k;
        clear_mon;
        make_exp(w, exp_seq);
        start(w);
        wait_done(1'b0, ok);
        exp_seq = (exp_seq + 1) % 256;
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: done_o not seen within bound");
        end
        vectors++;
        if (diff_bits() != 0) begin
            errors++;
            $display("FAIL basic_frame: %0d bit errors, got %0d bits required %0d", diff_bits(), rx.size(), FB);
        end
        vectors++;
        if (frame_cycles != FB * CD) begin
            errors++;
            $display("FAIL basic_len: frame cycles %0d required %0d", frame_cycles, FB * CD);
        end
        vectors++;
        if (sclk_edges != FB) begin
            errors++;
            $display("FAIL basic_edges: sclk edges %0d required %0d", sclk_edges, FB);
        end
        vectors++;
        if (rx.size() < FB || rx[FB-1] != 1'b0) begin
            errors++;
            $display("FAIL basic_parity: parity bit wrong or missing, %0d bits seen required 0 parity", rx.size());
        end
        vectors++;
        if (seq !== 8'(exp_seq) || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_seq: seq=%h busy=%b required %h 0", seq, busy, 8'(exp_seq));
        end
        tick;
        vectors++;
        if (done !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done: done=%b pulses=%0d required 0 1", done, done_cnt);
        end
    endtask

    task automatic test_parity;
        logic [NW-1:0][WD-1:0] w = '0;
        bit ok;
        w[0] = 32'h0000_0001;
        clear_mon;
        make_exp(w, exp_seq);
        start(w);
        wait_done(1'b0, ok);
        vectors++;
        if (!ok || diff_bits() != 0) begin
            errors++;
            $display("FAIL parity_frame: ok=%b bit errors %0d required 1 0", ok, diff_bits());
        end
        vectors++;
        if (rx.size() < FB || rx[FB-1] != 1'b1) begin
            errors++;
            $display("FAIL parity_bit: %0d bits seen, required parity 1", rx.size());
        end
        vectors++;
        if (rx_byte(8) !== 8'(exp_seq)) begin
            errors++;
            $display("FAIL parity_seq_byte: got %h required %h", rx_byte(8), 8'(exp_seq));
        end
        exp_seq = (exp_seq + 1) % 256;
        tick;
    endtask

    task automatic test_shadow_hold;
        logic [NW-1:0][WD-1:0] w;
        bit ok;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < NW; k++) w[k] = $urandom;
            clear_mon;
            make_exp(w, exp_seq);
            start(w);
            wait_done(1'b1, ok);
            exp_seq = (exp_seq + 1) % 256;
            vectors++;
            if (!ok || diff_bits() != 0) begin
                errors++;
                $display("FAIL shadow_frame%0d: ok=%b bit errors %0d required 1 0", f, ok, diff_bits());
            end
            vectors++;
            if (sclk_edges != FB || seq !== 8'(exp_seq)) begin
                errors++;
                $display("FAIL shadow_edges%0d: edges=%0d seq=%h required %0d %h", f, sclk_edges, seq, FB, 8'(exp_seq));
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [NW-1:0][WD-1:0] w;
        bit ok;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        for (int k = 0; k < NW; k++) w[k] = $urandom;
        mem = w;
        clear_mon;
        make_exp(w, exp_seq);
        req = 1'b1;
        tick;
        vectors++;
        if (busy !== 1'b1 || ovr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_cycle: busy=%b overrun=%b required 1 0", busy, ovr);
        end
        tick;
        vectors++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL b2b_overrun_set: overrun=%b required 1", ovr);
        end
        wait_done(1'b0, ok);
        exp_seq = (exp_seq + 1) % 256;
        vectors++;
        if (!ok || busy !== 1'b0 || diff_bits() != 0) begin
            errors++;
            $display("FAIL b2b_frame1: ok=%b busy=%b bit errors %0d required 1 0 0", ok, busy, diff_bits());
        end
        clr = 1'b1;
        clear_mon;
        make_exp(w, exp_seq);
        tick;
        clr = 1'b0;
        vectors++;
        if (busy !== 1'b1 || ovr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: busy=%b overrun=%b required 1 0", busy, ovr);
        end
        tick;
        vectors++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL b2b_overrun_reset: overrun=%b required 1", ovr);
        end
        req = 1'b0;
        wait_done(1'b0, ok);
        exp_seq = (exp_seq + 1) % 256;
        vectors++;
        if (!ok || diff_bits() != 0 || seq !== 8'(exp_seq)) begin
            errors++;
            $display("FAIL b2b_frame2: ok=%b bit errors %0d seq=%h required 1 0 %h", ok, diff_bits(), seq, 8'(exp_seq));
        end
        tick;
        vectors++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sticky: overrun=%b required 1", ovr);
        end
        clr = 1'b1;
        tick;
        clr = 1'b0;
        vectors++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_clear: overrun=%b required 0", ovr);
        end
    endtask

    task automatic test_reset_mid;
        logic [NW-1:0][WD-1:0] w;
        bit ok;
        for (int k = 0; k < NW; k++) w[k] = $urandom;
        clear_mon;
        start(w);
        repeat (16 * CD + 60) tick;
        vectors++;
        if (frame !== 1'b1 || seq === 8'h00) begin
            errors++;
            $display("FAIL midrst_pre: frame=%b seq=%h required 1 nonzero", frame, seq);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({so, sclk, frame, busy, done, ovr} !== 6'b0 || seq !== 8'h00) begin
            errors++;
            $display("FAIL midrst_outputs: got %b seq=%h required 000000 00", {so, sclk, frame, busy, done, ovr}, seq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_seq = 0;
        tick;
        for (int k = 0; k < NW; k++) w[k] = $urandom;
        clear_mon;
        make_exp(w, exp_seq);
        start(w);
        wait_done(1'b0, ok);
        exp_seq = 1;
        vectors++;
        if (!ok || diff_bits() != 0 || rx_byte(8) !== 8'h00) begin
            errors++;
            $display("FAIL midrst_frame: ok=%b bit errors %0d seq byte %h required 1 0 00", ok, diff_bits(), rx_byte(8));
        end
        tick;
    endtask

    task automatic test_seq_wrap;
        int frames = 0, edges = 0, bad = 0;
        logic wprev = 1'b0;
        bit wrx[$];
        logic [7:0] hb, sb;
        w_mem[0] = $urandom;
        w_req = 1'b1;
        for (int i = 0; i < 30000 && frames < 257; i++) begin
            tick;
            if (w_sclk === 1'b1 && wprev === 1'b0) begin
                edges++;
                if (frames == 256) wrx.push_back(w_so);
            end
            wprev = w_sclk;
            if (w_done === 1'b1) begin
                frames++;
                if (edges != WFB) bad++;
                edges = 0;
                if (frames == 256) begin
                    vectors++;
                    if (w_seq !== 8'h00) begin
                        errors++;
                        $display("FAIL wrap_seq: seq=%h required 00 after 256 frames", w_seq);
                    end
                end
            end
        end
        w_req = 1'b0;
        vectors++;
        if (frames != 257 || bad != 0) begin
            errors++;
            $display("FAIL wrap_frames: frames=%0d bad edge counts=%0d required 257 0", frames, bad);
        end
        hb = 'x;
        sb = 'x;
        if (wrx.size() >= 16)
            for (int i = 0; i < 8; i++) begin
                hb[7-i] = wrx[i];
                sb[7-i] = wrx[8+i];
            end
        vectors++;
        if (hb !== 8'hA5 || sb !== 8'h00) begin
            errors++;
            $display("FAIL wrap_frame257: header=%h seq byte=%h required a5 00", hb, sb);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_shadow_hold;
        test_back_to_back;
        test_reset_mid;
        test_seq_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
